// File: rtl/qr_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : qr_pkg
//  Description : Shared types and constants for the finder-pattern row
//                scanner: run records, scanner FSM states and the
//                1:1:3:1:1 ratio bounds (expressed as multiples of 1/14 of T).
//  Revision    : 1.0 - initial release
// ============================================================================
package qr_pkg;

    localparam int RUN_LEN_W = 11;   // run length / column width
    localparam int ROW_W     = 10;   // row index width
    localparam int TOT_W     = 13;   // 5-run total width
    localparam int PROD_W    = 16;   // ratio products; T is bounded by the row width

    localparam int RATIO_DEN = 14;
    localparam int CENTER_LO = 4;
    localparam int CENTER_HI = 8;
    localparam int SIDE_HI   = 3;

    typedef logic [RUN_LEN_W-1:0] run_len_t;

    typedef struct packed {
        run_len_t               len;
        logic [RUN_LEN_W-1:0]   start;
        logic                   dark;
    } run_rec_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic logic in_band(input logic [PROD_W-1:0] val,
                                     input logic [PROD_W-1:0] lo,
                                     input logic [PROD_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/finder_ratio_check.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : finder_ratio_check
//  Description : Registered 1:1:3:1:1 test over a 5-run window (r0 oldest).
//                Produces pass, total width T, centre x of r2 and the row,
//                one cycle after i_eval.
//  Ports       : clk, rst_n (async, active-low)
//                i_eval  - window is a candidate this cycle
//                i_runs  - five run records, index 0 oldest
//                i_row   - row of the window
//                o_pass / o_total / o_x / o_y - registered result
//  Revision    : 1.0 - initial release
// ============================================================================
module finder_ratio_check
    import qr_pkg::*;
#(
    parameter int MIN_TOTAL = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_eval,
    input  run_rec_t [4:0]       i_runs,
    input  logic [ROW_W-1:0]     i_row,
    output logic                 o_pass,
    output logic [TOT_W-1:0]     o_total,
    output logic [RUN_LEN_W-1:0] o_x,
    output logic [ROW_W-1:0]     o_y
);

    logic [TOT_W-1:0]     w_total;
    logic [PROD_W-1:0]    w_total_p;
    logic [PROD_W-1:0]    w_scaled [5];
    logic                 w_sides_ok;
    logic                 w_centre_ok;
    logic                 w_colours_ok;
    logic                 w_abut_ok;
    logic                 w_ok;

    logic                 r_pass;
    logic [TOT_W-1:0]     r_total;
    logic [RUN_LEN_W-1:0] r_x;
    logic [ROW_W-1:0]     r_y;

    always_comb begin
        w_total   = '0;
        w_abut_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_total     = w_total + TOT_W'(i_runs[i].len);
            w_scaled[i] = PROD_W'(RATIO_DEN) * PROD_W'(i_runs[i].len);
        end
        // Runs of a genuine window abut each other; anything else is stale.
        for (int i = 0; i < 4; i++) begin
            if (i_runs[i].start + i_runs[i].len != i_runs[i+1].start) begin
                w_abut_ok = 1'b0;
            end
        end
    end

    assign w_total_p    = PROD_W'(w_total);
    assign w_sides_ok   = in_band(w_scaled[0], w_total_p, PROD_W'(SIDE_HI) * w_total_p)
                        & in_band(w_scaled[1], w_total_p, PROD_W'(SIDE_HI) * w_total_p)
                        & in_band(w_scaled[3], w_total_p, PROD_W'(SIDE_HI) * w_total_p)
                        & in_band(w_scaled[4], w_total_p, PROD_W'(SIDE_HI) * w_total_p);
    assign w_centre_ok  = in_band(w_scaled[2], PROD_W'(CENTER_LO) * w_total_p,
                                  PROD_W'(CENTER_HI) * w_total_p);
    assign w_colours_ok = i_runs[0].dark & ~i_runs[1].dark & i_runs[2].dark
                        & ~i_runs[3].dark & i_runs[4].dark;
    assign w_ok         = (w_total >= TOT_W'(MIN_TOTAL)) & w_sides_ok & w_centre_ok
                        & w_colours_ok & w_abut_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass  <= 1'b0;
            r_total <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_pass <= i_eval & w_ok;
            if (i_eval) begin
                r_total <= w_total;
                r_x     <= i_runs[2].start + (i_runs[2].len >> 1);
                r_y     <= i_row;
            end
        end
    end

    assign o_pass  = r_pass;
    assign o_total = r_total;
    assign o_x     = r_x;
    assign o_y     = r_y;

endmodule
`default_nettype wire

// File: rtl/finder_row_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : finder_row_scanner
//  Description : Run-length encodes each row of a binarized pixel stream and
//                reports horizontal 1:1:3:1:1 finder cross-sections, plus a
//                per-frame hit count.
//  Ports       : clk_in, rst_in (async, active-low)
//                valid_in, pixel_in (0 = dark), hcount_in, vcount_in
//                frame_done_in    - end-of-frame pulse
//                hit_valid_out    - hit strobe; hit_x/y/width_out hold between
//                hit_count_out    - hits in the last completed frame
//  Revision    : 1.0 - initial release
// ============================================================================
module finder_row_scanner
    import qr_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int RUN_W     = 11,
    parameter int MIN_TOTAL = 14,
    parameter int CNT_W     = 10
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 valid_in,
    input  logic                 pixel_in,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic                 frame_done_in,
    output logic                 hit_valid_out,
    output logic [10:0]          hit_x_out,
    output logic [9:0]           hit_y_out,
    output logic [12:0]          hit_width_out,
    output logic [CNT_W-1:0]     hit_count_out
);

    localparam logic [10:0]      c_last_col = 11'(WIDTH - 1);
    localparam run_len_t         c_len_max  = run_len_t'((1 << RUN_W) - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    state_t           r_state,   w_state_nx;
    run_rec_t         r_cur,     w_cur_nx;
    run_rec_t [4:0]   r_hist,    w_hist_nx;     // index 0 oldest, 4 newest
    logic [2:0]       r_hcnt,    w_hcnt_nx;     // runs held in history, 0..5
    logic [10:0]      r_prev_h;
    logic [9:0]       r_prev_v;

    run_rec_t         w_open;
    run_rec_t         w_closed;
    run_rec_t [4:0]   w_pushed;
    logic [2:0]       w_pushed_cnt;
    run_len_t         w_len_inc;
    logic             w_row_end;
    logic             w_contig;
    logic             w_same;
    logic             w_eval;

    run_rec_t [4:0]   r_win;
    logic             r_eval;
    logic [9:0]       r_row;

    logic             w_chk_pass;
    logic [12:0]      w_chk_total;
    logic [10:0]      w_chk_x;
    logic [9:0]       w_chk_y;

    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_open    = '{len: run_len_t'(1), start: hcount_in, dark: ~pixel_in};
    assign w_row_end = (hcount_in == c_last_col);
    assign w_contig  = (hcount_in == r_prev_h + 11'd1) && (vcount_in == r_prev_v);
    assign w_same    = (~pixel_in == r_cur.dark);
    assign w_len_inc = (r_cur.len == c_len_max) ? r_cur.len : r_cur.len + run_len_t'(1);
    assign w_cnt_inc = (r_hit_cnt == c_cnt_max) ? r_hit_cnt : r_hit_cnt + CNT_W'(1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cur_nx     = r_cur;
        w_hist_nx    = r_hist;
        w_hcnt_nx    = r_hcnt;
        w_closed     = r_cur;
        w_pushed     = r_hist;
        w_pushed_cnt = r_hcnt;
        w_eval       = 1'b0;

        // End of frame wins over a coincident pixel, which is dropped.
        if (frame_done_in) begin
            w_state_nx = S_IDLE;
            w_hist_nx  = '0;
            w_hcnt_nx  = '0;
        end else if (valid_in) begin
            case (r_state)
                S_IDLE: begin
                    w_cur_nx   = w_open;
                    w_state_nx = S_RUN;
                end
                S_RUN: begin
                    if (!w_contig) begin
                        w_cur_nx  = w_open;
                        w_hist_nx = '0;
                        w_hcnt_nx = '0;
                    end else begin
                        if (w_same) begin
                            w_cur_nx     = r_cur;
                            w_cur_nx.len = w_len_inc;
                            w_closed     = w_cur_nx;
                        end else begin
                            w_cur_nx = w_open;
                        end
                        // On a colour change at the row end the 1-pixel run is
                        // simply never pushed.
                        if (!w_same || w_row_end) begin
                            w_pushed     = {w_closed, r_hist[4:1]};
                            w_pushed_cnt = (r_hcnt == 3'd5) ? r_hcnt : r_hcnt + 3'd1;
                            w_eval       = w_closed.dark && (w_pushed_cnt == 3'd5);
                            w_hist_nx    = w_pushed;
                            w_hcnt_nx    = w_pushed_cnt;
                        end
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
            if (w_row_end) begin
                w_state_nx = S_IDLE;
                w_hist_nx  = '0;
                w_hcnt_nx  = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cur    <= '0;
            r_hist   <= '0;
            r_hcnt   <= '0;
            r_prev_h <= '0;
            r_prev_v <= '0;
            r_win    <= '0;
            r_eval   <= 1'b0;
            r_row    <= '0;
        end else begin
            r_cur  <= w_cur_nx;
            r_hist <= w_hist_nx;
            r_hcnt <= w_hcnt_nx;
            r_eval <= w_eval;
            if (valid_in) begin
                r_prev_h <= hcount_in;
                r_prev_v <= vcount_in;
            end
            // The window is snapshotted because a row-end flush clears history
            // in the same cycle.
            if (w_eval) begin
                r_win <= w_pushed;
                r_row <= vcount_in;
            end
        end
    end

    finder_ratio_check #(
        .MIN_TOTAL (MIN_TOTAL)
    ) u_ratio (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .i_eval  (r_eval),
        .i_runs  (r_win),
        .i_row   (r_row),
        .o_pass  (w_chk_pass),
        .o_total (w_chk_total),
        .o_x     (w_chk_x),
        .o_y     (w_chk_y)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hit_valid_out <= 1'b0;
            hit_x_out     <= '0;
            hit_y_out     <= '0;
            hit_width_out <= '0;
        end else begin
            hit_valid_out <= w_chk_pass;
            if (w_chk_pass) begin
                hit_x_out     <= w_chk_x;
                hit_y_out     <= w_chk_y;
                hit_width_out <= w_chk_total;
            end
        end
    end

    // A strobe coincident with frame_done still belongs to the closing frame.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_hit_cnt     <= '0;
            hit_count_out <= '0;
        end else if (frame_done_in) begin
            hit_count_out <= hit_valid_out ? w_cnt_inc : r_hit_cnt;
            r_hit_cnt     <= '0;
        end else if (hit_valid_out) begin
            r_hit_cnt <= w_cnt_inc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_finder_row_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_finder_row_scanner
//  Description : Directed self-checking bench for finder_row_scanner. Each
//                expected hit is queued with the cycle it must strobe in; a
//                monitor pops and compares, and flags any unexpected strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_finder_row_scanner;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic        pixel_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        frame_done_in;
    logic        hit_valid_out;
    logic [10:0] hit_x_out;
    logic [9:0]  hit_y_out;
    logic [12:0] hit_width_out;
    logic [9:0]  hit_count_out;

    finder_row_scanner dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .valid_in      (valid_in),
        .pixel_in      (pixel_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .frame_done_in (frame_done_in),
        .hit_valid_out (hit_valid_out),
        .hit_x_out     (hit_x_out),
        .hit_y_out     (hit_y_out),
        .hit_width_out (hit_width_out),
        .hit_count_out (hit_count_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int cyc;
        int x;
        int y;
        int w;
    } exp_t;

    exp_t sb[$];
    int   lens[$];
    bit   row_bits [640];

    // Scoreboard monitor: every negedge either matches the head entry or
    // requires the strobe to be low.
    always @(negedge clk_in) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            assert (e.cyc == cyc && hit_valid_out === 1'b1) else begin
                failures++;
                $error("FAIL hit_strobe cyc=%0d observed valid=%b expected strobe at cyc=%0d", cyc, hit_valid_out, e.cyc);
            end
            checks++;
            assert ({hit_x_out, hit_y_out, hit_width_out} === {11'(e.x), 10'(e.y), 13'(e.w)}) else begin
                failures++;
                $error("FAIL hit_fields observed x=%0d y=%0d w=%0d expected x=%0d y=%0d w=%0d",
                       hit_x_out, hit_y_out, hit_width_out, e.x, e.y, e.w);
            end
        end else begin
            checks++;
            assert (hit_valid_out === 1'b0) else begin
                failures++;
                $error("FAIL spurious_hit cyc=%0d observed valid=%b x=%0d y=%0d expected valid=0", cyc, hit_valid_out, hit_x_out, hit_y_out);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Fill row_bits from lens with alternating colours; the remainder of the
    // row continues in the colour after the last listed run.
    task automatic build_row(input bit first_dark);
        int h;
        bit d;
        h = 0;
        d = first_dark;
        foreach (lens[i]) begin
            for (int k = 0; k < lens[i]; k++) begin
                row_bits[h] = ~d;
                h++;
            end
            d = ~d;
        end
        while (h < 640) begin
            row_bits[h] = ~d;
            h++;
        end
    endtask

    task automatic send_range(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) begin
            @(negedge clk_in);
            valid_in  = 1'b1;
            pixel_in  = row_bits[h];
            hcount_in = 11'(h);
            vcount_in = 10'(v);
        end
    endtask

    task automatic send_row(input int v);
        send_range(v, 0, 639);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            valid_in = 1'b0;
        end
    endtask

    task automatic frame_pulse();
        @(negedge clk_in);
        valid_in      = 1'b0;
        frame_done_in = 1'b1;
        @(negedge clk_in);
        frame_done_in = 1'b0;
    endtask

    // Called at a negedge just before send_row: pixel 0 goes out at the next
    // negedge (cyc+1), the closing pixel is sampled at the edge after
    // cyc+1+h_close, and the strobe is visible two edges later.
    task automatic expect_hit(input int h_close, input int x, input int y, input int w);
        exp_t e;
        e.cyc = cyc + h_close + 4;
        e.x   = x;
        e.y   = y;
        e.w   = w;
        sb.push_back(e);
    endtask

    initial begin
        rst_in        = 1'b0;
        valid_in      = 1'b0;
        pixel_in      = 1'b0;
        hcount_in     = '0;
        vcount_in     = '0;
        frame_done_in = 1'b0;
        idle(3);
        check("reset_valid", 32'(hit_valid_out), 0);
        check("reset_x",     32'(hit_x_out), 0);
        check("reset_y",     32'(hit_y_out), 0);
        check("reset_width", 32'(hit_width_out), 0);
        check("reset_count", 32'(hit_count_out), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(3);

        // ---------------- Frame A: five hits ----------------
        lens = '{100, 7, 7, 21, 7, 7};
        build_row(1'b0);
        expect_hit(149, 124, 5, 49);
        send_row(5);
        idle(4);

        lens = '{7, 7, 7, 7, 7};                    // equal runs: centre too thin
        build_row(1'b1);
        send_row(6);
        idle(4);

        lens = '{605, 7, 7, 21};                    // pattern split over rows 7/8
        build_row(1'b0);
        send_row(7);
        lens = '{7, 7};
        build_row(1'b0);
        send_row(8);
        idle(4);

        lens = '{1, 1, 3, 1, 1};                    // T = 7 below minimum
        build_row(1'b1);
        send_row(9);
        idle(4);

        lens = '{20, 2, 2, 6, 2, 2};                // T = 14 exactly at minimum
        build_row(1'b0);
        expect_hit(34, 27, 10, 14);
        send_row(10);
        idle(4);

        lens = '{591, 7, 7, 21, 7, 7};              // r4 ends on the last column
        build_row(1'b0);
        expect_hit(639, 615, 11, 49);
        send_row(11);
        idle(4);

        lens = '{10, 7, 7, 21, 7, 7, 7, 21, 7, 7};  // two overlapping patterns
        build_row(1'b0);
        expect_hit(59, 34, 12, 49);
        expect_hit(101, 76, 12, 49);
        send_row(12);
        idle(4);

        frame_pulse();
        check("frameA_count", 32'(hit_count_out), 5);
        check("hold_x",       32'(hit_x_out), 76);
        check("hold_y",       32'(hit_y_out), 12);
        check("hold_width",   32'(hit_width_out), 49);
        idle(3);

        // ---------------- Frame B: 4th strobe coincides with frame_done ----------------
        lens = '{100, 7, 7, 21, 7, 7};
        build_row(1'b0);
        expect_hit(149, 124, 20, 49);
        send_row(20);
        idle(4);

        lens = '{10, 7, 7, 21, 7, 7, 7, 21, 7, 7};
        build_row(1'b0);
        expect_hit(59, 34, 21, 49);
        expect_hit(101, 76, 21, 49);
        send_row(21);
        idle(4);

        lens = '{591, 7, 7, 21, 7, 7};
        build_row(1'b0);
        expect_hit(639, 615, 22, 49);
        send_row(22);
        idle(2);
        frame_pulse();                              // frame_done in the strobe cycle
        check("frameB_count", 32'(hit_count_out), 4);
        idle(3);

        // ---------------- Frame C: no hits ----------------
        lens = '{7, 7, 7, 7, 7};
        build_row(1'b1);
        send_row(30);
        idle(4);
        check("count_holds", 32'(hit_count_out), 4);
        frame_pulse();
        check("frameC_count", 32'(hit_count_out), 0);
        idle(3);

        // ---------------- Frame E: single hit ----------------
        lens = '{100, 7, 7, 21, 7, 7};
        build_row(1'b0);
        expect_hit(149, 124, 40, 49);
        send_row(40);
        idle(4);
        frame_pulse();
        check("frameE_count", 32'(hit_count_out), 1);
        idle(3);

        // ---------------- Asynchronous reset inside r3 ----------------
        lens = '{100, 7, 7, 21, 7, 7};
        build_row(1'b0);
        send_range(41, 0, 137);
        @(negedge clk_in);
        rst_in   = 1'b0;
        valid_in = 1'b0;
        #1;
        check("async_rst_valid", 32'(hit_valid_out), 0);
        check("async_rst_x",     32'(hit_x_out), 0);
        check("async_rst_y",     32'(hit_y_out), 0);
        check("async_rst_width", 32'(hit_width_out), 0);
        check("async_rst_count", 32'(hit_count_out), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        send_range(41, 138, 639);
        idle(8);
        check("post_rst_x", 32'(hit_x_out), 0);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
